// File: rtl/switch_pkg.sv
// Shared encodings for the switch crossbar: allocator FSM states and one-hot mux selects.
package switch_pkg;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  localparam logic [3:0] SEL_NONE = 4'b0000;
  localparam logic [3:0] SEL_IN0  = 4'b0001;
  localparam logic [3:0] SEL_IN1  = 4'b0010;
  localparam logic [3:0] SEL_IN2  = 4'b0100;
  localparam logic [3:0] SEL_IN3  = 4'b1000;

endpackage

// File: rtl/rr_pick_4.sv
// Combinational 4-way round-robin picker: first requester at or after ptr, wrapping mod 4.
module rr_pick_4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic       any,
  output logic [1:0] win_idx,
  output logic [3:0] win_onehot
);

  always_comb begin
    logic [1:0] idx;
    any        = 1'b0;
    win_idx    = 2'd0;
    win_onehot = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!any && req[idx]) begin
        any        = 1'b1;
        win_idx    = idx;
        win_onehot = 4'b0001 << idx;
      end
    end
  end

endmodule

// File: rtl/output_allocator_4.sv
// Per-output-port wormhole allocator: round-robin grant among 4 inputs, held until tail transfer.
module output_allocator_4
  import switch_pkg::*;
#(
  parameter int unsigned N_IN    = 4,
  parameter int unsigned RR_INIT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] flit_valid,
  input  logic [3:0] flit_tail,
  input  logic       out_stall,
  output logic [3:0] mux_sel,
  output logic       out_valid,
  output logic [3:0] in_stall,
  output logic       busy
);

  if (N_IN != 4) begin : g_bad_n_in
    $error("output_allocator_4 supports only N_IN == 4");
  end
  if (RR_INIT > 3) begin : g_bad_rr_init
    $error("output_allocator_4 requires RR_INIT in 0..3");
  end

  logic [0:0] state_q, state_d;
  logic [3:0] sel_q, sel_d;
  logic [1:0] ptr_q, ptr_d;

  logic       pick_any;
  logic [1:0] pick_idx;
  logic [3:0] pick_onehot;
  logic [1:0] w;
  logic       sel_ok;
  logic       xfer_tail;

  rr_pick_4 u_rr_pick (
    .req        (req),
    .ptr        (ptr_q),
    .any        (pick_any),
    .win_idx    (pick_idx),
    .win_onehot (pick_onehot)
  );

  always_comb begin
    w      = 2'd0;
    sel_ok = 1'b1;
    case (sel_q)
      SEL_IN0: w = 2'd0;
      SEL_IN1: w = 2'd1;
      SEL_IN2: w = 2'd2;
      SEL_IN3: w = 2'd3;
      default: sel_ok = 1'b0;
    endcase
  end

  assign xfer_tail = flit_valid[w] & flit_tail[w] & ~out_stall;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          sel_d   = pick_onehot;
          ptr_d   = pick_idx + 2'd1;
          state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        // A corrupted (non one-hot) select is treated like an illegal state.
        if (xfer_tail || !sel_ok) begin
          sel_d   = SEL_NONE;
          state_d = ST_IDLE;
        end
      end
      default: begin
        sel_d   = SEL_NONE;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= SEL_NONE;
      ptr_q   <= 2'(RR_INIT);
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  assign busy      = (state_q == ST_LOCKED);
  assign mux_sel   = sel_q;
  assign out_valid = busy & flit_valid[w];
  assign in_stall  = ~({4{busy}} & sel_q) | {4{out_stall}};

endmodule

// File: tb/tb_output_allocator_4.sv
// Directed self-checking bench for output_allocator_4 (RR_INIT = 0).
module tb_output_allocator_4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] flit_valid;
  logic [3:0] flit_tail;
  logic       out_stall;
  logic [3:0] mux_sel;
  logic       out_valid;
  logic [3:0] in_stall;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  output_allocator_4 #(
    .N_IN    (4),
    .RR_INIT (0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .flit_valid (flit_valid),
    .flit_tail  (flit_tail),
    .out_stall  (out_stall),
    .mux_sel    (mux_sel),
    .out_valid  (out_valid),
    .in_stall   (in_stall),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst_n      = 1'b0;
    req        = 4'b0000;
    flit_valid = 4'b0000;
    flit_tail  = 4'b0000;
    out_stall  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++;
    if (mux_sel !== 4'b0000 || busy !== 1'b0 || out_valid !== 1'b0 || in_stall !== 4'b1111) begin
      n_fail++;
      $display("FAIL reset: mux_sel=%b busy=%b out_valid=%b in_stall=%b, want 0000 0 0 1111",
               mux_sel, busy, out_valid, in_stall);
    end
    // Idle cycles must not move the pointer: first grant after idling still goes to input 0.
    step();
    step();
    req = 4'b0011; flit_valid = 4'b0011; flit_tail = 4'b0011;
    step();
    n_checks++;
    if (mux_sel !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_idle_ptr: mux_sel=%b want 0001", mux_sel);
    end
  endtask

  task automatic test_single_flit_rr();
    logic [3:0] exp_sel [5];
    exp_sel[0] = 4'b0001; exp_sel[1] = 4'b0000; exp_sel[2] = 4'b0100;
    exp_sel[3] = 4'b0000; exp_sel[4] = 4'b0001;
    do_reset();
    req = 4'b0101; flit_valid = 4'b1111; flit_tail = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      step();
      n_checks++;
      if (mux_sel !== exp_sel[c]) begin
        n_fail++;
        $display("FAIL single_flit_rr cycle%0d: mux_sel=%b want %b", c + 1, mux_sel, exp_sel[c]);
      end
    end
    n_checks++;
    if (out_valid !== 1'b1 || in_stall !== 4'b1110) begin
      n_fail++;
      $display("FAIL single_flit_rr_outs: out_valid=%b in_stall=%b want 1 1110", out_valid, in_stall);
    end
  endtask

  task automatic test_packet(input logic stall_tail);
    int xfers;
    xfers = 0;
    do_reset();
    req = 4'b0010; flit_valid = 4'b0010; flit_tail = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      step();
      req       = 4'b0000;
      flit_tail = (k == 3) ? 4'b0010 : 4'b0000;
      out_stall = (k == 3) ? stall_tail : 1'b0;
      #1;
      n_checks++;
      if (mux_sel !== 4'b0010 || out_valid !== 1'b1 || busy !== 1'b1 ||
          in_stall !== ((k == 3 && stall_tail) ? 4'b1111 : 4'b1101)) begin
        n_fail++;
        $display("FAIL packet flit%0d stall=%b: mux_sel=%b out_valid=%b busy=%b in_stall=%b",
                 k + 1, stall_tail, mux_sel, out_valid, busy, in_stall);
      end
      if (out_valid && !in_stall[1]) xfers++;
    end
    if (stall_tail) begin
      step();
      n_checks++;
      if (mux_sel !== 4'b0010) begin
        n_fail++;
        $display("FAIL packet_tail_held: mux_sel=%b want 0010", mux_sel);
      end
      out_stall = 1'b0;
      #1;
      if (out_valid && !in_stall[1]) xfers++;
    end
    step();
    n_checks++;
    if (mux_sel !== 4'b0000 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL packet_release stall=%b: mux_sel=%b busy=%b want 0000 0",
               stall_tail, mux_sel, busy);
    end
    n_checks++;
    if (xfers != 4) begin
      n_fail++;
      $display("FAIL packet_xfer_count stall=%b: got %0d want 4", stall_tail, xfers);
    end
    flit_valid = 4'b0000;
    flit_tail  = 4'b0000;
  endtask

  task automatic test_back_to_back();
    logic [3:0] order [6];
    order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
    order[3] = 4'b1000; order[4] = 4'b0001; order[5] = 4'b0010;
    do_reset();
    req = 4'b1111; flit_valid = 4'b1111; flit_tail = 4'b1111;
    for (int g = 0; g < 6; g++) begin
      step();
      n_checks++;
      if (mux_sel !== order[g]) begin
        n_fail++;
        $display("FAIL back_to_back grant%0d: mux_sel=%b want %b", g, mux_sel, order[g]);
      end
      step();
      n_checks++;
      if (mux_sel !== 4'b0000) begin
        n_fail++;
        $display("FAIL back_to_back gap%0d: mux_sel=%b want 0000", g, mux_sel);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 4'b0100; flit_valid = 4'b0100; flit_tail = 4'b0000;
    step();
    req = 4'b0000;
    step();
    n_checks++;
    if (mux_sel !== 4'b0100 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset_pre: mux_sel=%b busy=%b want 0100 1", mux_sel, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (mux_sel !== 4'b0000 || busy !== 1'b0 || in_stall !== 4'b1111 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_drop: mux_sel=%b busy=%b in_stall=%b out_valid=%b",
               mux_sel, busy, in_stall, out_valid);
    end
    #1 rst_n = 1'b1;
    req = 4'b1111; flit_valid = 4'b1111; flit_tail = 4'b1111;
    step();
    n_checks++;
    if (mux_sel !== 4'b0001) begin
      n_fail++;
      $display("FAIL async_reset_restart: mux_sel=%b want 0001", mux_sel);
    end
  endtask

  task automatic test_hold_no_valid();
    do_reset();
    req = 4'b1000; flit_valid = 4'b0000; flit_tail = 4'b0000;
    step();
    req = 4'b0001; flit_valid = 4'b0001; flit_tail = 4'b0001;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++;
      if (mux_sel !== 4'b1000 || out_valid !== 1'b0 || in_stall[0] !== 1'b1 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL hold_no_valid cycle%0d: mux_sel=%b out_valid=%b in_stall=%b busy=%b",
                 c, mux_sel, out_valid, in_stall, busy);
      end
      step();
    end
    flit_valid = 4'b1001; flit_tail = 4'b1001;
    step();
    n_checks++;
    if (mux_sel !== 4'b0000) begin
      n_fail++;
      $display("FAIL hold_release: mux_sel=%b want 0000", mux_sel);
    end
    step();
    n_checks++;
    if (mux_sel !== 4'b0001) begin
      n_fail++;
      $display("FAIL hold_next_grant: mux_sel=%b want 0001", mux_sel);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    req        = 4'b0000;
    flit_valid = 4'b0000;
    flit_tail  = 4'b0000;
    out_stall  = 1'b0;
    test_reset();
    test_single_flit_rr();
    test_packet(1'b0);
    test_packet(1'b1);
    test_back_to_back();
    test_async_reset();
    test_hold_no_valid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
